apb_master_bridge: RTL and testbench

- Single-outstanding APB initiator that turns a valid/ready command stream into APB transfers for the peripheral bus (GPIO and similar responders).
- Each accepted command runs as one APB SETUP/ACCESS transfer. The result comes back on a valid/ready response stream.
- Adds a bounded-wait timeout so that a responder holding pREADY low cannot hang the bus.

---
 rtl/apb_master_bridge_if.sv | 49 ++++
 rtl/apb_master_bridge.sv | 165 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Bundle of the command stream, response stream and APB bus seen by the bridge.
//   master modport : the bridge (drives APB requests, cmd_ready and the response)
//   slave  modport : the environment (command source, response sink, APB responder)
interface apb_master_bridge_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  localparam int unsigned CW = 1 + DW + AW;

  // Command stream, packed as {write, wdata, addr}
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_data;

  // Response stream
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rsp_timeout;

  // APB bus
  logic [AW-1:0] pADDR;
  logic          pSEL;
  logic          pENABLE;
  logic          pWRITE;
  logic [DW-1:0] pWDATA;
  logic [DW-1:0] pRDATA;
  logic          pREADY;
  logic          pSLVERR;

  modport master (
    input  cmd_valid, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_err, rsp_timeout,
    input  rsp_ready,
    output pADDR, pSEL, pENABLE, pWRITE, pWDATA,
    input  pRDATA, pREADY, pSLVERR
  );

  modport slave (
    output cmd_valid, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_err, rsp_timeout,
    output rsp_ready,
    input  pADDR, pSEL, pENABLE, pWRITE, pWDATA,
    output pRDATA, pREADY, pSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: one command -> one SETUP/ACCESS transfer -> one response.
// A bounded ACCESS wait aborts the transfer if the responder never raises pREADY.
//   pCLK    : clock
//   pRESETn : asynchronous active-low reset
//   bus     : command stream in, response stream out, APB initiator signals
module apb_master_bridge #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 32,
  parameter int unsigned TO_CYC = 16
) (
  input  logic                 pCLK,
  input  logic                 pRESETn,
  apb_master_bridge_if.master  bus
);

  localparam int unsigned CW    = 1 + DW + AW;
  localparam int unsigned RW    = DW;
  localparam int unsigned CNT_W = (TO_CYC == 0) ? 1 : $clog2(TO_CYC + 1);

  localparam bit               TO_EN    = (TO_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    paddr_q, paddr_d;
  logic [DW-1:0]    pwdata_q, pwdata_d;
  logic             pwrite_q, pwrite_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]    rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_to_q, rsp_to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Command field split
  logic          cmd_write;
  logic [DW-1:0] cmd_wdata;
  logic [AW-1:0] cmd_addr;

  assign cmd_write = bus.cmd_data[CW-1];
  assign cmd_wdata = bus.cmd_data[AW +: DW];
  assign cmd_addr  = bus.cmd_data[AW-1:0];

  // Ready depends on state only so the source never sees a combinational loop
  assign bus.cmd_ready   = (state_q == ST_IDLE);

  assign bus.pADDR       = paddr_q;
  assign bus.pWDATA      = pwdata_q;
  assign bus.pWRITE      = pwrite_q;
  assign bus.pSEL        = psel_q;
  assign bus.pENABLE     = penable_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          pwrite_d  = cmd_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        // pREADY is checked first so a completion on the limit cycle is not a timeout
        if (bus.pREADY) begin
          // Read data is only meaningful for a successful read
          rsp_data_d  = (pwrite_q || bus.pSLVERR) ? '0 : bus.pRDATA;
          rsp_err_d   = bus.pSLVERR;
          rsp_to_d    = 1'b0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (TO_EN && (cnt_q == TO_LIMIT)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge pCLK or negedge pRESETn) begin
    if (!pRESETn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, randomized
// transfers against a behavioural model, and an asynchronous reset in ACCESS.
module tb_apb_master_bridge;

  localparam int TO = 16;

  logic pCLK;
  logic pRESETn;

  apb_master_bridge_if #(.DW(32), .AW(32)) bus ();

  apb_master_bridge #(.DW(32), .AW(32), .TO_CYC(TO)) dut (
    .pCLK    (pCLK),
    .pRESETn (pRESETn),
    .bus     (bus)
  );

  initial pCLK = 1'b0;
  always #5 pCLK = ~pCLK;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] addr;
    int          waits;   // ACCESS cycles with pREADY low before it rises
    logic [31:0] rdata;
    bit          slverr;
    int          stall;   // cycles rsp_ready is held low after rsp_valid
    bit          keep;    // keep cmd_valid high through the transfer
    logic [31:0] e_data;
    bit          e_err;
    bit          e_to;
    int          e_lat;   // negedges after the accept edge until rsp_valid is seen
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: outcome of one transfer from the responder's behaviour alone
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (TO != 0 && v.waits >= TO) begin
      r.e_data = 32'h0; r.e_err = 1'b1; r.e_to = 1'b1; r.e_lat = 2 + TO;
    end else begin
      r.e_data = v.wr ? 32'h0 : v.rdata;
      r.e_err  = v.slverr; r.e_to = 1'b0; r.e_lat = 3 + v.waits;
    end
    return r;
  endfunction

  // Runs one full transfer; entered and left at a negedge with the bridge idle
  task automatic run_txn(input vec_t v, input string tag);
    int lat = 0, acc = 0, psel_cnt = 0, bad = 0, exp_psel;
    bit seen = 0, rdy;
    chk({tag, ".cmd_ready_idle"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {v.wr, v.wdata, v.addr};
    bus.rsp_ready = 1'b0;
    bus.pREADY    = 1'b0;
    @(posedge pCLK);
    for (int n = 1; n <= 60; n++) begin
      @(negedge pCLK);
      if (!v.keep) bus.cmd_valid = 1'b0;
      if (n == 1) begin
        chk({tag, ".setup_sel_en"}, 64'({bus.pSEL, bus.pENABLE}), 64'b10);
        chk({tag, ".setup_addr"}, 64'(bus.pADDR), 64'(v.addr));
        chk({tag, ".setup_wdata_wr"}, {31'd0, bus.pWRITE, bus.pWDATA}, {31'd0, v.wr, v.wdata});
      end
      if (bus.rsp_valid) begin
        lat = n; seen = 1; break;
      end
      if (bus.pSEL) begin
        psel_cnt++;
        if (bus.pADDR !== v.addr || bus.pWRITE !== v.wr || bus.pWDATA !== v.wdata) bad++;
      end
      if (bus.pSEL && bus.pENABLE) begin
        rdy = (acc >= v.waits);
        acc++;
        bus.pREADY  = rdy;
        bus.pRDATA  = rdy ? v.rdata : (32'hBAD0_0000 | 32'(acc));
        bus.pSLVERR = rdy ? v.slverr : 1'b1;
      end else begin
        bus.pREADY  = 1'($urandom_range(0, 1));
        bus.pSLVERR = 1'b1;
        bus.pRDATA  = $urandom;
      end
    end
    bus.pREADY = 1'b0; bus.pSLVERR = 1'b0;
    if (!seen) begin
      chk({tag, ".rsp_valid_bound"}, 64'd0, 64'd1);
      return;
    end
    exp_psel = v.e_to ? 1 + TO : v.waits + 2;
    chk({tag, ".latency"}, 64'(lat), 64'(v.e_lat));
    chk({tag, ".rsp_data"}, 64'(bus.rsp_data), 64'(v.e_data));
    chk({tag, ".err_to"}, 64'({bus.rsp_err, bus.rsp_timeout}), 64'({v.e_err, v.e_to}));
    chk({tag, ".psel_cycles"}, 64'(psel_cnt), 64'(exp_psel));
    chk({tag, ".bus_idle_in_resp"}, 64'({bus.pSEL, bus.pENABLE}), 64'd0);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge pCLK);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== v.e_data || bus.rsp_err !== v.e_err ||
          bus.rsp_timeout !== v.e_to || bus.cmd_ready !== 1'b0 || bus.pSEL !== 1'b0) bad++;
    end
    chk({tag, ".stable"}, 64'(bad), 64'd0);
    bus.rsp_ready = 1'b1;
    @(negedge pCLK);
    bus.rsp_ready = 1'b0;
    chk({tag, ".after_hs"}, 64'({bus.rsp_valid, bus.cmd_ready}), 64'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int bad;

    pRESETn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    bus.pRDATA = '0; bus.pREADY = 1'b0; bus.pSLVERR = 1'b0;

    tbl[0] = '{wr:1, wdata:32'h0000_A5A5, addr:32'h04, waits:0,   rdata:32'h1111_2222, slverr:0, stall:0, keep:0,
               e_data:32'h0, e_err:0, e_to:0, e_lat:3};
    tbl[1] = '{wr:0, wdata:32'h0,         addr:32'h00, waits:2,   rdata:32'h0000_1234, slverr:0, stall:1, keep:0,
               e_data:32'h0000_1234, e_err:0, e_to:0, e_lat:5};
    tbl[2] = '{wr:1, wdata:32'h0000_00FF, addr:32'h08, waits:0,   rdata:32'h3333_4444, slverr:1, stall:0, keep:0,
               e_data:32'h0, e_err:1, e_to:0, e_lat:3};
    tbl[3] = '{wr:0, wdata:32'h0,         addr:32'h10, waits:100, rdata:32'h5555_6666, slverr:0, stall:0, keep:0,
               e_data:32'h0, e_err:1, e_to:1, e_lat:18};
    tbl[4] = '{wr:0, wdata:32'h0,         addr:32'h14, waits:15,  rdata:32'h0000_CAFE, slverr:0, stall:0, keep:0,
               e_data:32'h0000_CAFE, e_err:0, e_to:0, e_lat:18};
    tbl[5] = '{wr:1, wdata:32'h1357_9BDF, addr:32'h20, waits:1,   rdata:32'h7777_8888, slverr:0, stall:5, keep:1,
               e_data:32'h0, e_err:0, e_to:0, e_lat:4};
    tbl[6] = '{wr:0, wdata:32'h0,         addr:32'h24, waits:0,   rdata:32'h5555_AAAA, slverr:0, stall:0, keep:0,
               e_data:32'h5555_AAAA, e_err:0, e_to:0, e_lat:3};
    tbl[7] = '{wr:1, wdata:32'hFFFF_0000, addr:32'h28, waits:16,  rdata:32'h9999_0000, slverr:0, stall:2, keep:0,
               e_data:32'h0, e_err:1, e_to:1, e_lat:18};

    #2;
    chk("reset.apb_ctl", 64'({bus.pSEL, bus.pENABLE, bus.pWRITE}), 64'd0);
    chk("reset.addr_wdata", {bus.pADDR, bus.pWDATA}, 64'd0);
    chk("reset.rsp", {bus.rsp_data, 29'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 64'd0);
    chk("reset.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge pCLK);
    pRESETn = 1'b1;
    @(negedge pCLK);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.wr     = 1'($urandom_range(0, 1));
      v.wdata  = $urandom;
      v.addr   = $urandom;
      v.waits  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 18));
      v.rdata  = $urandom;
      v.slverr = v.wr ? 1'($urandom_range(0, 1)) : 1'b0;
      v.stall  = int'($urandom_range(0, 3));
      v.keep   = 1'($urandom_range(0, 1));
      v = model(v);
      run_txn(v, $sformatf("rnd%0d", i));
    end
    bus.cmd_valid = 1'b0;
    @(negedge pCLK);

    // Asynchronous reset while the responder stalls in ACCESS
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {1'b0, 32'h0, 32'h0000_0040};
    bus.pREADY    = 1'b0;
    @(posedge pCLK);
    @(negedge pCLK);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge pCLK);
    chk("arst.in_access", 64'({bus.pSEL, bus.pENABLE}), 64'b11);
    #2 pRESETn = 1'b0;
    #1;
    chk("arst.bus_dropped", 64'({bus.pSEL, bus.pENABLE, bus.rsp_valid}), 64'd0);
    chk("arst.addr_cleared", 64'(bus.pADDR), 64'd0);
    @(negedge pCLK);
    pRESETn = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge pCLK);
      if (bus.rsp_valid !== 1'b0 || bus.pSEL !== 1'b0 || bus.cmd_ready !== 1'b1) bad++;
    end
    chk("arst.quiet_after", 64'(bad), 64'd0);
    run_txn(tbl[1], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
